// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   DEF_WIDTH : default operand/result width
//   state_t   : control FSM state encodings
package serial_subtractor_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle between a controlling FSM and the serial subtractor.
//   master : drives start/a/b/bin, observes busy/done/diff/bout/ovf/zero
//   slave  : the subtractor side of the same bundle
interface serial_subtractor_if
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) ();

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;
    logic             zero;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout, ovf, zero
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout, ovf, zero
    );

endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor built from gate primitives.
//   a, b, bin : minuend bit, subtrahend bit, borrow-in
//   d         : difference bit  a ^ b ^ bin
//   bout      : borrow-out      (~a & b) | (~(a ^ b) & bin)
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic axb;
    logic na;
    logic naxb;
    logic t_gen;
    logic t_prop;

    xor g_axb  (axb, a, b);
    xor g_d    (d, axb, bin);
    not g_na   (na, a);
    not g_naxb (naxb, axb);
    and g_gen  (t_gen, na, b);
    and g_prop (t_prop, naxb, bin);
    or  g_bout (bout, t_gen, t_prop);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of serial_subtractor_if
//                start/a/b/bin sampled in IDLE; busy during SHIFT;
//                done pulses one cycle; diff/bout/ovf/zero registered and
//                held until the next completion.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    serial_subtractor_if.slave bus
);

    state_t           state;
    state_t           next_state;

    // sa doubles as the partial-result register: each bit of a is consumed
    // from the LSB while the matching difference bit enters at the MSB, so
    // after WIDTH shifts sa would hold the full difference.
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic             br;
    logic             a_msb;
    logic             b_msb;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] diff_r;
    logic             bout_r;
    logic             ovf_r;
    logic             zero_r;

    logic             d_bit;
    logic             br_next;
    logic             last_bit;
    logic [WIDTH-1:0] diff_final;
    logic             busy_o;
    logic             done_o;

    full_subtractor u_cell (
        .a    (sa[0]),
        .b    (sb[0]),
        .bin  (br),
        .d    (d_bit),
        .bout (br_next)
    );

    assign last_bit   = (state == ST_SHIFT) && (cnt == CNT_W'(WIDTH - 1));
    assign diff_final = {d_bit, sa[WIDTH-1:1]};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    // Next-state logic; the unused encoding falls back to IDLE
    always_comb begin
        next_state = ST_IDLE;
        case (state)
            ST_IDLE:  next_state = bus.start ? ST_SHIFT : ST_IDLE;
            ST_SHIFT: next_state = last_bit  ? ST_DONE  : ST_SHIFT;
            ST_DONE:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        busy_o = 1'b0;
        done_o = 1'b0;
        case (state)
            ST_SHIFT: busy_o = 1'b1;
            ST_DONE:  done_o = 1'b1;
            default:  ;
        endcase
    end

    // Datapath: operand capture, serial shift, result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa     <= '0;
            sb     <= '0;
            br     <= 1'b0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            cnt    <= '0;
            diff_r <= '0;
            bout_r <= 1'b0;
            ovf_r  <= 1'b0;
            zero_r <= 1'b0;
        end else if (state == ST_IDLE && bus.start) begin
            sa    <= bus.a;
            sb    <= bus.b;
            br    <= bus.bin;
            a_msb <= bus.a[WIDTH-1];
            b_msb <= bus.b[WIDTH-1];
            cnt   <= '0;
        end else if (state == ST_SHIFT) begin
            sa <= {d_bit, sa[WIDTH-1:1]};
            sb <= {1'b0, sb[WIDTH-1:1]};
            br <= br_next;
            if (last_bit) begin
                // Counter holds at WIDTH-1; it is reloaded on the next accept
                diff_r <= diff_final;
                bout_r <= br_next;
                ovf_r  <= (a_msb != b_msb) && (d_bit != a_msb);
                zero_r <= (diff_final == '0);
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign bus.busy = busy_o;
    assign bus.done = done_o;
    assign bus.diff = diff_r;
    assign bus.bout = bout_r;
    assign bus.ovf  = ovf_r;
    assign bus.zero = zero_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_serial_subtractor;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    int   lat, bn, ndone, consec, prev_done;
    int   t_done [3];

    serial_subtractor_if #(.WIDTH(8)) bus ();

    serial_subtractor #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_res(input string tag, input logic [7:0] e_diff,
                             input logic e_bout, input logic e_ovf, input logic e_zero);
        check({tag, ".diff"}, 32'(bus.diff), 32'(e_diff));
        check({tag, ".bout"}, 32'(bus.bout), 32'(e_bout));
        check({tag, ".ovf"},  32'(bus.ovf),  32'(e_ovf));
        check({tag, ".zero"}, 32'(bus.zero), 32'(e_zero));
    endtask

    // Presents operands with start for one cycle; returns one cycle after accept
    task automatic start_op(input logic [7:0] ta, input logic [7:0] tb_, input logic tbin);
        @(negedge clk);
        bus.a = ta; bus.b = tb_; bus.bin = tbin; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Waits (bounded) for done; lat counts edges after accept, bn busy cycles
    task automatic wait_done(output int l, output int n);
        l = 0; n = 0;
        while (bus.done !== 1'b1 && l < 40) begin
            if (bus.busy === 1'b1) n++;
            @(negedge clk);
            l++;
        end
        check("done_seen", 32'(bus.done), 32'd1);
    endtask

    task automatic count_done(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) n++;
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.bin = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst.busy", 32'(bus.busy), 32'd0);
        check("rst.done", 32'(bus.done), 32'd0);
        check_res("rst", 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // 5 - 3 with latency and busy length
        start_op(8'h05, 8'h03, 1'b0);
        wait_done(lat, bn);
        check("t1.latency", 32'(lat), 32'd8);
        check("t1.busy_cycles", 32'(bn), 32'd8);
        check_res("t1", 8'h02, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("t1.done_pulse", 32'(bus.done), 32'd0);
        check("t1.idle_busy", 32'(bus.busy), 32'd0);

        // Borrow cases
        start_op(8'h03, 8'h05, 1'b0);
        wait_done(lat, bn);
        check_res("t2a", 8'hFE, 1'b1, 1'b0, 1'b0);
        start_op(8'h00, 8'h00, 1'b1);
        wait_done(lat, bn);
        check_res("t2b", 8'hFF, 1'b1, 1'b0, 1'b0);

        // Signed overflow cases
        start_op(8'h80, 8'h01, 1'b0);
        wait_done(lat, bn);
        check_res("t3a", 8'h7F, 1'b0, 1'b1, 1'b0);
        start_op(8'h7F, 8'hFF, 1'b0);
        wait_done(lat, bn);
        check_res("t3b", 8'h80, 1'b1, 1'b1, 1'b0);

        // Zero result; start re-pulsed and operands changed mid-operation
        start_op(8'h55, 8'h55, 1'b0);
        @(negedge clk);
        bus.a = 8'hAA; bus.b = 8'h11; bus.bin = 1'b1; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("t4.held_diff", 32'(bus.diff), 32'h80);
        check("t4.held_ovf", 32'(bus.ovf), 32'd1);
        check("t4.busy", 32'(bus.busy), 32'd1);
        wait_done(lat, bn);
        check_res("t4", 8'h00, 1'b0, 1'b0, 1'b1);
        count_done(15, ndone);
        check("t4.extra_done", 32'(ndone), 32'd0);

        // Asynchronous reset mid-operation
        start_op(8'h10, 8'h01, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t5.busy", 32'(bus.busy), 32'd0);
        check("t5.done", 32'(bus.done), 32'd0);
        check_res("t5", 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        count_done(15, ndone);
        check("t5.no_done", 32'(ndone), 32'd0);
        start_op(8'h10, 8'h01, 1'b0);
        wait_done(lat, bn);
        check("t5.latency", 32'(lat), 32'd8);
        check_res("t5b", 8'h0F, 1'b0, 1'b0, 1'b0);

        // Back-to-back with start held high
        @(negedge clk);
        bus.a = 8'h05; bus.b = 8'h03; bus.bin = 1'b0; bus.start = 1'b1;
        ndone = 0; consec = 0; prev_done = 0;
        t_done[0] = 0; t_done[1] = 0; t_done[2] = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                if (prev_done == 1) consec++;
                if (ndone < 3) t_done[ndone] = i;
                ndone++;
                prev_done = 1;
            end else begin
                prev_done = 0;
            end
        end
        bus.start = 1'b0;
        check("t6.gap1", 32'(t_done[1] - t_done[0]), 32'd10);
        check("t6.gap2", 32'(t_done[2] - t_done[1]), 32'd10);
        check("t6.consecutive", 32'(consec), 32'd0);
        check_res("t6", 8'h02, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
